// File: rtl/packet_queue_pkg.sv
// Shared sizing, types and helpers for the MESSAGE2PACKET packet queue.
package packet_queue_pkg;

    localparam int QUEUE_WIDTH         = 8;
    localparam int FLIT_WIDTH          = 8;
    localparam int BUS_DATA_WIDTH      = FLIT_WIDTH;
    localparam int MAX_PACKET_LENGHT   = 5;
    localparam int MAX_BURST_LENGHT    = MAX_PACKET_LENGHT - 1;
    localparam int N_BITS_POINTER      = 3;
    localparam int N_BITS_BURST_LENGHT = 7;
    localparam int FLIT_IDX_W          = $clog2(MAX_PACKET_LENGHT);
    localparam int LINK_WIDTH          = MAX_PACKET_LENGHT * FLIT_WIDTH;

    typedef logic [N_BITS_POINTER-1:0]      ptr_t;
    typedef logic [N_BITS_BURST_LENGHT-1:0] burst_cnt_t;
    typedef logic [FLIT_IDX_W-1:0]          flit_idx_t;
    typedef logic [FLIT_WIDTH-1:0]          flit_t;
    typedef logic [MAX_PACKET_LENGHT-1:0]   sel_t;

    localparam ptr_t       PTR_ZERO   = ptr_t'(32'd0);
    localparam ptr_t       PTR_ONE    = ptr_t'(32'd1);
    localparam ptr_t       PTR_LAST   = ptr_t'(QUEUE_WIDTH - 1);
    localparam burst_cnt_t BURST_ZERO = burst_cnt_t'(32'd0);
    localparam burst_cnt_t BURST_ONE  = burst_cnt_t'(32'd1);
    localparam burst_cnt_t BURST_MAX  = burst_cnt_t'(MAX_BURST_LENGHT);

    typedef enum logic [0:0] {
        ASM_IDLE    = 1'b0,
        ASM_COLLECT = 1'b1
    } asm_state_e;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t n;
        if (p == PTR_LAST) begin
            n = PTR_ZERO;
        end else begin
            n = p + PTR_ONE;
        end
        return n;
    endfunction

endpackage

// File: rtl/packet_queue_if.sv
// Bus-side message input and flits-buffer output handshake of the packet queue.
interface packet_queue_if;
    import packet_queue_pkg::*;

    logic                  accept_o;
    logic                  head_valid_i;
    flit_t                 head_i;
    logic                  data_valid_i;
    logic [BUS_DATA_WIDTH-1:0] data_i;
    logic                  last_i;
    logic                  abort_i;
    logic                  overflow_o;
    logic [LINK_WIDTH-1:0] out_link_o;
    sel_t                  out_sel_o;
    logic                  r_msg_to_pkt_o;
    logic                  g_msg_to_pkt_i;

    modport master (
        input  accept_o, overflow_o, out_link_o, out_sel_o, r_msg_to_pkt_o,
        output head_valid_i, head_i, data_valid_i, data_i, last_i, abort_i, g_msg_to_pkt_i
    );

    modport slave (
        output accept_o, overflow_o, out_link_o, out_sel_o, r_msg_to_pkt_o,
        input  head_valid_i, head_i, data_valid_i, data_i, last_i, abort_i, g_msg_to_pkt_i
    );

endinterface

// File: rtl/packet_queue_slot_ram.sv
// Packet slot storage: one flit write port at the tail slot, one combinational read of the head slot.
module packet_queue_slot_ram
    import packet_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_header,
    input  ptr_t                  wr_slot,
    input  flit_idx_t             wr_idx,
    input  flit_t                 wr_flit,
    input  ptr_t                  rd_slot,
    output logic [LINK_WIDTH-1:0] rd_link,
    output sel_t                  rd_sel
);

    flit_t flits_r [QUEUE_WIDTH][MAX_PACKET_LENGHT];
    sel_t  sel_r   [QUEUE_WIDTH];

    // A header write restarts the slot's sel so stale bits of an aborted message vanish.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            flits_r[wr_slot][wr_idx] <= wr_flit;
            if (wr_header) begin
                sel_r[wr_slot] <= {{(MAX_PACKET_LENGHT-1){1'b0}}, 1'b1};
            end else begin
                sel_r[wr_slot][wr_idx] <= 1'b1;
            end
        end
    end

    // Flatten the head slot into the output link, flit 0 in the low bits.
    always_comb begin
        rd_link = {LINK_WIDTH{1'b0}};
        for (int i = 0; i < MAX_PACKET_LENGHT; i++) begin
            rd_link[i*FLIT_WIDTH +: FLIT_WIDTH] = flits_r[rd_slot][i];
        end
        rd_sel = sel_r[rd_slot];
    end

endmodule

// File: rtl/packet_queue.sv
// MESSAGE2PACKET queue: assembles bus messages into circular packet slots and drains them by request/grant.
// Optional PACKET_QUEUE_COUNT_EN adds count_o, the registered number of valid slots.
module packet_queue
    import packet_queue_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    packet_queue_if.slave bus
`ifdef PACKET_QUEUE_COUNT_EN
    ,
    output logic [N_BITS_POINTER:0] count_o
`endif
);

    asm_state_e             state_r;
    asm_state_e             state_s;
    logic [QUEUE_WIDTH-1:0] valid_bit_r;
    ptr_t                   head_pointer_r;
    ptr_t                   tail_pointer_r;
    burst_cnt_t             chunk_ptr_r;
    logic                   overflow_r;

    logic                   accept_s;
    logic                   hdr_take_s;
    logic                   chunk_take_s;
    logic                   drop_s;
    logic                   commit_s;
    logic                   grant_s;
    logic                   req_s;
    burst_cnt_t             chunk_next_s;
    flit_idx_t              wr_idx_s;
    flit_t                  wr_flit_s;
    logic [LINK_WIDTH-1:0]  rd_link_s;
    sel_t                   rd_sel_s;

    // Assembly next-state and beat decode; abort outranks any data beat in COLLECT.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        hdr_take_s   = 1'b0;
        chunk_take_s = 1'b0;
        drop_s       = 1'b0;
        commit_s     = 1'b0;
        chunk_next_s = chunk_ptr_r + BURST_ONE;
        case (state_r)
            ASM_IDLE: begin
                accept_s   = !valid_bit_r[tail_pointer_r];
                hdr_take_s = bus.head_valid_i && accept_s;
                commit_s   = hdr_take_s && bus.last_i;
                if (hdr_take_s && !bus.last_i) begin
                    state_s = ASM_COLLECT;
                end else begin
                    state_s = ASM_IDLE;
                end
            end
            ASM_COLLECT: begin
                if (bus.abort_i) begin
                    state_s = ASM_IDLE;
                end else if (bus.data_valid_i) begin
                    if (chunk_ptr_r < BURST_MAX) begin
                        chunk_take_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                    if (bus.last_i) begin
                        commit_s = 1'b1;
                        state_s  = ASM_IDLE;
                    end else begin
                        state_s = ASM_COLLECT;
                    end
                end else begin
                    state_s = ASM_COLLECT;
                end
            end
            default: begin
                state_s = ASM_IDLE;
            end
        endcase
    end

    // Write port steering and grant qualification.
    always_comb begin
        grant_s = bus.g_msg_to_pkt_i && valid_bit_r[head_pointer_r];
        req_s   = valid_bit_r[head_pointer_r];
        if (hdr_take_s) begin
            wr_idx_s  = flit_idx_t'(32'd0);
            wr_flit_s = bus.head_i;
        end else begin
            wr_idx_s  = flit_idx_t'(chunk_next_s);
            wr_flit_s = bus.data_i;
        end
    end

    // Assembly state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ASM_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Slot occupancy, pointers, chunk counter and overflow pulse; commit and grant never hit the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bit_r    <= {QUEUE_WIDTH{1'b0}};
            head_pointer_r <= PTR_ZERO;
            tail_pointer_r <= PTR_ZERO;
            chunk_ptr_r    <= BURST_ZERO;
            overflow_r     <= 1'b0;
        end else begin
            if (commit_s) begin
                valid_bit_r[tail_pointer_r] <= 1'b1;
                tail_pointer_r              <= ptr_inc(tail_pointer_r);
            end
            if (grant_s) begin
                valid_bit_r[head_pointer_r] <= 1'b0;
                head_pointer_r              <= ptr_inc(head_pointer_r);
            end
            if (hdr_take_s) begin
                chunk_ptr_r <= BURST_ZERO;
            end else if (chunk_take_s) begin
                chunk_ptr_r <= chunk_next_s;
            end
            overflow_r <= drop_s;
        end
    end

`ifdef PACKET_QUEUE_COUNT_EN
    logic [N_BITS_POINTER:0] count_r;

    // Occupancy counter; a simultaneous commit and grant cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {(N_BITS_POINTER+1){1'b0}};
        end else begin
            case ({commit_s, grant_s})
                2'b10:   count_r <= count_r + {{N_BITS_POINTER{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{N_BITS_POINTER{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign count_o = count_r;
`endif

    packet_queue_slot_ram u_slot_ram (
        .clk       (clk),
        .wr_en     (hdr_take_s || chunk_take_s),
        .wr_header (hdr_take_s),
        .wr_slot   (tail_pointer_r),
        .wr_idx    (wr_idx_s),
        .wr_flit   (wr_flit_s),
        .rd_slot   (head_pointer_r),
        .rd_link   (rd_link_s),
        .rd_sel    (rd_sel_s)
    );

    assign bus.accept_o       = accept_s;
    assign bus.overflow_o     = overflow_r;
    assign bus.r_msg_to_pkt_o = req_s;
    assign bus.out_link_o     = req_s ? rd_link_s : {LINK_WIDTH{1'b0}};
    assign bus.out_sel_o      = req_s ? rd_sel_s : {MAX_PACKET_LENGHT{1'b0}};

endmodule

// File: tb/tb_packet_queue.sv
// Directed self-checking bench for packet_queue (optionally built with PACKET_QUEUE_COUNT_EN).
module tb_packet_queue;
    import packet_queue_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    packet_queue_if bus();

`ifdef PACKET_QUEUE_COUNT_EN
    logic [N_BITS_POINTER:0] count;
    packet_queue dut (.clk(clk), .rst(rst), .bus(bus), .count_o(count));
`else
    packet_queue dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.head_valid_i   = 1'b0;
        bus.head_i         = 8'h00;
        bus.data_valid_i   = 1'b0;
        bus.data_i         = 8'h00;
        bus.last_i         = 1'b0;
        bus.abort_i        = 1'b0;
        bus.g_msg_to_pkt_i = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] h, input logic last);
        bus.head_valid_i = 1'b1;
        bus.head_i       = h;
        bus.last_i       = last;
        step();
        idle_inputs();
    endtask

    task automatic send_data(input logic [7:0] d, input logic last);
        bus.data_valid_i = 1'b1;
        bus.data_i       = d;
        bus.last_i       = last;
        step();
        idle_inputs();
    endtask

    task automatic grant();
        bus.g_msg_to_pkt_i = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (bus.accept_o !== 1'b1) begin n_err++; $display("FAIL reset_accept: got %b want 1", bus.accept_o); end
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.r_msg_to_pkt_o); end
        n_cmp++; if (bus.out_sel_o !== 5'b00000) begin n_err++; $display("FAIL reset_sel: got %b want 00000", bus.out_sel_o); end
        n_cmp++; if (bus.out_link_o !== 40'h0) begin n_err++; $display("FAIL reset_link: got %h want 0", bus.out_link_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_o); end
`ifdef PACKET_QUEUE_COUNT_EN
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
`endif
    endtask

    task automatic test_single();
        send_header(8'hA5, 1'b1);
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b1) begin n_err++; $display("FAIL single_req: got %b want 1", bus.r_msg_to_pkt_o); end
        n_cmp++; if (bus.out_sel_o !== 5'b00001) begin n_err++; $display("FAIL single_sel: got %b want 00001", bus.out_sel_o); end
        n_cmp++; if (bus.out_link_o[7:0] !== 8'hA5) begin n_err++; $display("FAIL single_flit0: got %h want a5", bus.out_link_o[7:0]); end
        n_cmp++; if (bus.accept_o !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b want 1", bus.accept_o); end
        grant();
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b0) begin n_err++; $display("FAIL single_req_after_grant: got %b want 0", bus.r_msg_to_pkt_o); end
        n_cmp++; if (bus.out_link_o !== 40'h0) begin n_err++; $display("FAIL single_link_cleared: got %h want 0", bus.out_link_o); end
    endtask

    task automatic test_burst();
        send_header(8'h40, 1'b0);
        n_cmp++; if (bus.accept_o !== 1'b0) begin n_err++; $display("FAIL burst_accept_collect: got %b want 0", bus.accept_o); end
        send_data(8'h11, 1'b0);
        send_data(8'h22, 1'b0);
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b0) begin n_err++; $display("FAIL burst_req_early: got %b want 0", bus.r_msg_to_pkt_o); end
        send_data(8'h33, 1'b1);
        n_cmp++; if (bus.out_sel_o !== 5'b01111) begin n_err++; $display("FAIL burst_sel: got %b want 01111", bus.out_sel_o); end
        n_cmp++; if (bus.out_link_o[31:0] !== 32'h33221140) begin n_err++; $display("FAIL burst_link: got %h want 33221140", bus.out_link_o[31:0]); end
        n_cmp++; if (bus.accept_o !== 1'b1) begin n_err++; $display("FAIL burst_accept_idle: got %b want 1", bus.accept_o); end
        grant();
    endtask

    task automatic test_full();
        for (int i = 0; i < QUEUE_WIDTH; i++) begin
            send_header(8'h80 + 8'(i), 1'b1);
        end
        n_cmp++; if (bus.accept_o !== 1'b0) begin n_err++; $display("FAIL full_accept: got %b want 0", bus.accept_o); end
`ifdef PACKET_QUEUE_COUNT_EN
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", count); end
`endif
        send_header(8'hEE, 1'b1);
        n_cmp++; if (bus.out_link_o[7:0] !== 8'h80) begin n_err++; $display("FAIL full_ignored_hdr: got %h want 80", bus.out_link_o[7:0]); end
        grant();
        n_cmp++; if (bus.accept_o !== 1'b1) begin n_err++; $display("FAIL full_accept_freed: got %b want 1", bus.accept_o); end
        n_cmp++; if (bus.out_link_o[7:0] !== 8'h81) begin n_err++; $display("FAIL full_next_head: got %h want 81", bus.out_link_o[7:0]); end
        send_header(8'h99, 1'b1);
        n_cmp++; if (bus.accept_o !== 1'b0) begin n_err++; $display("FAIL full_accept_refull: got %b want 0", bus.accept_o); end
        for (int i = 1; i < QUEUE_WIDTH; i++) begin
            n_cmp++; if (bus.out_link_o[7:0] !== 8'h80 + 8'(i)) begin n_err++; $display("FAIL full_drain_%0d: got %h want %h", i, bus.out_link_o[7:0], 8'h80 + 8'(i)); end
            grant();
        end
        n_cmp++; if (bus.out_link_o[7:0] !== 8'h99) begin n_err++; $display("FAIL full_wrapped_slot: got %h want 99", bus.out_link_o[7:0]); end
        grant();
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b0) begin n_err++; $display("FAIL full_empty_req: got %b want 0", bus.r_msg_to_pkt_o); end
    endtask

    task automatic test_abort();
        send_header(8'h50, 1'b0);
        send_data(8'hAA, 1'b0);
        send_data(8'hBB, 1'b0);
        bus.abort_i      = 1'b1;
        bus.data_valid_i = 1'b1;
        bus.data_i       = 8'hCC;
        bus.last_i       = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b0) begin n_err++; $display("FAIL abort_req: got %b want 0", bus.r_msg_to_pkt_o); end
        n_cmp++; if (bus.accept_o !== 1'b1) begin n_err++; $display("FAIL abort_accept: got %b want 1", bus.accept_o); end
        send_header(8'h60, 1'b0);
        send_data(8'h61, 1'b1);
        n_cmp++; if (bus.out_sel_o !== 5'b00011) begin n_err++; $display("FAIL abort_reuse_sel: got %b want 00011", bus.out_sel_o); end
        n_cmp++; if (bus.out_link_o[15:0] !== 16'h6160) begin n_err++; $display("FAIL abort_reuse_link: got %h want 6160", bus.out_link_o[15:0]); end
        grant();
    endtask

    task automatic test_overflow();
        send_header(8'h70, 1'b0);
        for (int i = 1; i <= MAX_BURST_LENGHT; i++) begin
            send_data(8'h70 + 8'(i), 1'b0);
        end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", bus.overflow_o); end
        send_data(8'h75, 1'b1);
        n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow_o); end
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b1) begin n_err++; $display("FAIL ovf_commit: got %b want 1", bus.r_msg_to_pkt_o); end
        n_cmp++; if (bus.out_sel_o !== 5'b11111) begin n_err++; $display("FAIL ovf_sel: got %b want 11111", bus.out_sel_o); end
        n_cmp++; if (bus.out_link_o !== 40'h7473727170) begin n_err++; $display("FAIL ovf_link: got %h want 7473727170", bus.out_link_o); end
        step();
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle: got %b want 0", bus.overflow_o); end
        grant();
    endtask

    task automatic test_back_to_back();
        send_header(8'h01, 1'b1);
        send_header(8'h02, 1'b0);
        n_cmp++; if (bus.out_link_o[7:0] !== 8'h01) begin n_err++; $display("FAIL b2b_first: got %h want 01", bus.out_link_o[7:0]); end
        bus.data_valid_i   = 1'b1;
        bus.data_i         = 8'h03;
        bus.last_i         = 1'b1;
        bus.g_msg_to_pkt_i = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b1) begin n_err++; $display("FAIL b2b_req: got %b want 1", bus.r_msg_to_pkt_o); end
        n_cmp++; if (bus.out_sel_o !== 5'b00011) begin n_err++; $display("FAIL b2b_sel: got %b want 00011", bus.out_sel_o); end
        n_cmp++; if (bus.out_link_o[15:0] !== 16'h0302) begin n_err++; $display("FAIL b2b_link: got %h want 0302", bus.out_link_o[15:0]); end
`ifdef PACKET_QUEUE_COUNT_EN
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL b2b_count: got %0d want 1", count); end
`endif
        grant();
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", bus.r_msg_to_pkt_o); end
    endtask

    task automatic test_reset_mid();
        send_header(8'h0F, 1'b1);
        send_header(8'h0E, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (bus.r_msg_to_pkt_o !== 1'b0) begin n_err++; $display("FAIL rstmid_req: got %b want 0", bus.r_msg_to_pkt_o); end
        n_cmp++; if (bus.accept_o !== 1'b1) begin n_err++; $display("FAIL rstmid_accept: got %b want 1", bus.accept_o); end
        n_cmp++; if (bus.out_sel_o !== 5'b00000) begin n_err++; $display("FAIL rstmid_sel: got %b want 00000", bus.out_sel_o); end
        send_header(8'h0D, 1'b1);
        n_cmp++; if (bus.out_link_o[7:0] !== 8'h0D) begin n_err++; $display("FAIL rstmid_new: got %h want 0d", bus.out_link_o[7:0]); end
        n_cmp++; if (bus.out_sel_o !== 5'b00001) begin n_err++; $display("FAIL rstmid_new_sel: got %b want 00001", bus.out_sel_o); end
`ifdef PACKET_QUEUE_COUNT_EN
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL rstmid_count: got %0d want 1", count); end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_abort();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_queue.md
# packet_queue

Queue of the MESSAGE2PACKET stage, the reverse path of the NIC. Bus-side messages (a header flit plus 0..`MAX_BURST_LENGHT` data chunks delivered by the WISHBONE slave interface) are assembled into packet slots. Complete packets are presented one at a time to the output port (flits buffer) with a request/grant handshake. Slots are in a circular FIFO of `QUEUE_WIDTH` entries.

## Interface
- N_BITS_POINTER, 3, width of head/tail pointers; 2^N_BITS_POINTER >= `QUEUE_WIDTH
- N_BITS_BURST_LENGHT, 7, width of chunk counter; must hold `MAX_BURST_LENGHT
- Width rule: `BUS_DATA_WIDTH == `FLIT_WIDTH; `MAX_BURST_LENGHT == `MAX_PACKET_LENGHT-1
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- accept_o  out  1  ready for a new message header
- head_valid_i  in  1  head_i carries a message header
- head_i  in  `FLIT_WIDTH  header flit, pre-formatted
- data_valid_i  in  1  data_i carries the next chunk
- data_i  in  `BUS_DATA_WIDTH  data chunk
- last_i  in  1  qualifies head_valid_i or data_valid_i as the final beat of the message
- abort_i  in  1  discard the message under assembly (bus retry)
- overflow_o  out  1  one-cycle pulse: chunk dropped, message already full
- out_link_o  out  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet at head slot; flit 0 is the header
- out_sel_o  out  `MAX_PACKET_LENGHT  bit i high means flit i is valid
- r_msg_to_pkt_o  out  1  packet available at head slot
- g_msg_to_pkt_i  in  1  one-cycle grant; head packet consumed at this edge

## Operation
- State: valid_bit_r[`QUEUE_WIDTH]; per-slot flit storage and sel; head_pointer_r; tail_pointer_r; chunk_ptr_r.
- Assembly FSM, two states:
  - IDLE
    - accept_o = !valid_bit_r[tail_pointer_r].
    - head_valid_i && accept_o: store head_i in slot[tail] flit 0; set sel to bit0 only; clear chunk_ptr_r.
    - If last_i is also high, commit. Otherwise go to COLLECT.
    - head_valid_i while accept_o=0 is ignored. The sender must hold it.
  - COLLECT
    - accept_o = 0.
    - data_valid_i with chunk_ptr_r < `MAX_BURST_LENGHT: write the chunk to flit chunk_ptr_r+1; set that sel bit; chunk_ptr_r++.
    - data_valid_i with chunk_ptr_r == `MAX_BURST_LENGHT: the chunk is dropped and overflow_o pulses. last_i on that beat still commits.
    - data_valid_i && last_i: commit and go to IDLE.
    - abort_i has priority over data_valid_i: go to IDLE. Slot and tail are unchanged, and the partial data is overwritten by the next message.
- Commit: valid_bit_r[tail] <= 1. tail_pointer_r increments and wraps from `QUEUE_WIDTH-1 to 0.
- Drain:
  - r_msg_to_pkt_o = valid_bit_r[head_pointer_r].
  - out_link_o and out_sel_o show slot[head]. Both are forced to 0 while r_msg_to_pkt_o=0.
  - g_msg_to_pkt_i (only when r_msg_to_pkt_o=1; otherwise ignored): valid_bit_r[head] <= 0. head_pointer_r increments with wrap.
- Simultaneous commit and grant: both take effect in the same edge. They always target different slots, because the commit slot is invalid.
- Full queue: accept_o=0 in IDLE until a grant frees the tail slot.
- Reset: state IDLE; pointers 0; valid_bit_r 0; chunk_ptr_r 0. Outputs after reset: accept_o=1, r_msg_to_pkt_o=0, out_sel_o=0, out_link_o=0, overflow_o=0.
- Reset mid-assembly or mid-drain drops everything. No partial packet survives.

## Timing
- Commit edge (last beat) -> r_msg_to_pkt_o high the next cycle. This is 1 cycle of latency when the slot is at head.
- Grant edge -> r_msg_to_pkt_o and out_* reflect the next slot the following cycle.
- accept_o is combinational from registered state only. There is no input-to-output combinational path on the bus side.
- overflow_o is registered: high for exactly the cycle after the dropped beat.
- Back-to-back messages: IDLE is re-entered on the commit edge, so a new header is accepted the very next cycle if a slot is free.

## Configuration
- PACKET_QUEUE_COUNT_EN
  - Defined: adds output count_o [N_BITS_POINTER:0], the registered number of valid slots. It increments on commit, decrements on grant, is unchanged when both happen, and resets to 0.
  - Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- `QUEUE_WIDTH, `FLIT_WIDTH, `MAX_PACKET_LENGHT, `BUS_DATA_WIDTH, `MAX_BURST_LENGHT and the FSM state encodings live in NIC-defines.v.
- One natural sub-module: packet_queue_slot_ram, the slot storage (flits + sel) with one write port at tail and one combinational read port at head.

## Test plan
- Header 0xA5 with last_i, no data -> r_msg_to_pkt_o=1 next cycle, out_sel_o=...0001, flit0=0xA5; grant -> r=0 next cycle.
- Header + 3 chunks 0x11,0x22,0x33 (last on 0x33) -> out_sel_o=...1111, flits 1..3 in order.
- Fill `QUEUE_WIDTH messages with no grant -> accept_o=0. One grant -> accept_o=1 next cycle. Next message lands in the freed slot, showing tail wrap to 0.
- Header + 2 chunks then abort_i -> no request. Next message occupies the same slot, with no stale sel bits from the aborted message.
- `MAX_BURST_LENGHT+1 chunks -> overflow_o pulses once; the packet holds the first `MAX_BURST_LENGHT chunks.
- Commit and grant on the same edge with 1 entry queued -> r stays 1, new packet shown, count_o unchanged when PACKET_QUEUE_COUNT_EN is defined.
